// File: rtl/cg_enable_ctrl.sv
// Clock-gating enable controller for one gated TCPA region.
// Runs on the ungated clock. It gates the region after a programmable idle period,
// ungates it on a wake request or on pending work, and counts gating events.
module cg_enable_ctrl #(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int EVT_W       = 16
) (
    input  logic             ck_in,
    input  logic             rst_n,
    input  logic             cg_en,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic             busy,
    input  logic             act_pending,
    input  logic             wake_req,
    output logic             wake_ack,
    input  logic             test,
    output logic             cg_enable,
    output logic             cg_test,
    output logic             gated,
    output logic [EVT_W-1:0] gate_evt_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_e;

    localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             cg_enable_q, cg_enable_d;
    logic             wake_ack_q, wake_ack_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0]   wake_cnt_q, wake_cnt_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic             idle;
    logic [CNT_W-1:0] thresh_m1;

    // Any wake source keeps idle low, so a threshold hit coinciding with a wake never gates.
    assign idle      = ~busy & ~act_pending & ~wake_req & cg_en & (idle_thresh != '0) & ~test;
    assign thresh_m1 = idle_thresh - CNT_W'(1);

    always_ff @(posedge ck_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cg_enable_q <= 1'b1;
            wake_ack_q  <= 1'b0;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            evt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cg_enable_q <= cg_enable_d;
            wake_ack_q  <= wake_ack_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cg_enable_d = cg_enable_q;
        idle_cnt_d  = idle_cnt_q;
        wake_cnt_d  = wake_cnt_q;
        evt_cnt_d   = evt_cnt_q;

        case (state_q)
            RUN: begin
                cg_enable_d = 1'b1;
                if (!idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == thresh_m1) begin
                    state_d     = GATED;
                    cg_enable_d = 1'b0;
                    idle_cnt_d  = '0;
                    if (evt_cnt_q != '1) begin
                        evt_cnt_d = evt_cnt_q + EVT_W'(1);
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            GATED: begin
                // busy is stale while the region has no clock, so it plays no part here.
                if (wake_req | act_pending | ~cg_en | test) begin
                    state_d     = WAKE;
                    cg_enable_d = 1'b1;
                    wake_cnt_d  = '0;
                end
            end
            WAKE: begin
                cg_enable_d = 1'b1;
                wake_cnt_d  = wake_cnt_q + WCW'(1);
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d     = RUN;
                cg_enable_d = 1'b1;
                idle_cnt_d  = '0;
            end
        endcase
    end

    // The ack is only raised once the region has been back in RUN with a stable clock.
    always_comb begin
        wake_ack_d = wake_ack_q;
        if (!wake_req) begin
            wake_ack_d = 1'b0;
        end else if (state_q == RUN) begin
            wake_ack_d = 1'b1;
        end
    end

    assign cg_enable    = cg_enable_q;
    assign wake_ack     = wake_ack_q;
    assign gated        = (state_q == GATED);
    assign cg_test      = test;
    assign gate_evt_cnt = evt_cnt_q;

endmodule

// File: doc/cg_enable_ctrl.md
Name: cg_enable_ctrl

Overview:
- Sequential controller that generates the enable and test inputs of the team's clock-gating cell wrapper (my_CG_MOD) for one gated TCPA region.
- Lives in the always-on global controller domain, clocked by the ungated clock.
- Gates the region after a programmable idle period.
- Ungates it on a 4-phase wake request or on pending activity, then acknowledges once the clock has been stable for a fixed number of cycles.
- Counts gating events for power statistics.

Parameters:
- CNT_W, 8, width of the idle counter and of the idle_thresh port.
- WAKE_CYCLES, 2, ungated cycles (>=1) in WAKE before returning to RUN.
- EVT_W, 16, width of the gating-event counter.

Ports:
- ck_in  in  1  free-running ungated clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cg_en  in  1  gating allowed; 0 forces the region ungated.
- idle_thresh  in  CNT_W  consecutive idle cycles required before gating; 0 disables gating.
- busy  in  1  activity flag from the gated region; only meaningful while the region is clocked.
- act_pending  in  1  work queued from the ungated side; level wake, no ack.
- wake_req  in  1  4-phase wake request.
- wake_ack  out  1  4-phase wake acknowledge.
- test  in  1  scan/test mode.
- cg_enable  out  1  to the gating cell E; registered.
- cg_test  out  1  to the gating cell TE; equals test, combinational pass-through.
- gated  out  1  status: 1 while the clock is off (state GATED).
- gate_evt_cnt  out  EVT_W  number of RUN->GATED transitions, saturating.

Behaviour:
- Reset values: state=RUN, cg_enable=1, wake_ack=0, gated=0, idle_cnt=0, wake_cnt=0, gate_evt_cnt=0. Reset is asynchronous; deassertion takes effect at the first edge.
- idle condition (idle) = !busy & !act_pending & !wake_req & cg_en & (idle_thresh!=0) & !test.
- State RUN (cg_enable=1):
  - idle: idle_cnt<=idle_cnt+1.
  - Not idle: idle_cnt<=0.
  - idle & idle_cnt==idle_thresh-1: next state GATED, cg_enable<=0, idle_cnt<=0, gate_evt_cnt++ (holds at all-ones).
  - Latency: gating occurs on the idle_thresh-th consecutive idle edge.
- State GATED (cg_enable=0, gated=1):
  - busy is ignored.
  - wake_req | act_pending | !cg_en | test: next state WAKE, cg_enable<=1, wake_cnt<=0.
- State WAKE (cg_enable=1, gated=0):
  - wake_cnt increments each edge.
  - When wake_cnt==WAKE_CYCLES-1: next state RUN, idle_cnt<=0.
  - Wake sources are not re-evaluated; WAKE always completes.
- wake_ack (registered):
  - Set on the edge where state==RUN & wake_req.
  - Cleared on the edge where wake_req==0.
  - While wake_ack=1 the region cannot gate (wake_req keeps idle false).
  - wake_req deasserting before ack is legal; no ack is then issued.
  - A wake_req that is already high while in RUN gets an ack one edge later.
- test=1:
  - In RUN: idle_cnt held at 0 and no gating.
  - In GATED: ungates via WAKE.
  - cg_test=1 immediately, so the cell passes the clock regardless of E.
- Simultaneous events:
  - Idle threshold reached on the same edge act_pending/wake_req rises: no gating, because idle is already false.
  - idle_thresh changed mid-count: compare uses the current value; if idle_cnt >= new idle_thresh, wait until the counter wraps. Software must change idle_thresh only with cg_en=0.
- idle_cnt wraps modulo 2^CNT_W. It cannot exceed idle_thresh-1 in normal use.
- Reset asserted mid-operation (any state): immediately RUN, cg_enable=1. The clock is restored asynchronously.

Test Plan:
- Reset, idle_thresh=8, cg_en=1, busy=0 from edge 1 -> cg_enable falls after edge 8, gated=1, gate_evt_cnt=1.
- Gated, pulse wake_req high at edge k -> cg_enable=1 after k, RUN after k+2, wake_ack=1 after k+3; drop wake_req at m -> wake_ack=0 after m.
- idle_thresh=8, busy pulses high for 1 cycle after 5 idle edges -> counter restarts; gating only after 8 further consecutive idle edges.
- idle_thresh=0, or cg_en=0, for 300 cycles -> cg_enable stays 1, gate_evt_cnt=0. Also: gated state, drop cg_en -> WAKE then RUN.
- Gated, assert test -> cg_test=1 same cycle, cg_enable=1 next edge; no re-gating while test=1.
- Gated, assert rst_n=0 between edges -> cg_enable=1, gated=0 immediately. With EVT_W=4, 20 gating cycles -> gate_evt_cnt=15.
